// File: rtl/deal_sequencer.sv
// Turn-based card dealing controller: accepts keypad draw keys, requests a random card, and credits it to the current player.
// Draw latency is 3 cycles, from the key edge to the turn toggle or game end; keys are ignored while a draw is in flight.
module deal_sequencer #(
    parameter int TARGET    = 21,
    parameter int MAX_CARDS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] keypad_in,
    input  logic [4:0] rnd,
    output logic       rnd_en,
    output logic       whose,
    output logic       card_valid,
    output logic [1:0] card_color,
    output logic [2:0] card_number,
    output logic       card_owner,
    output logic [5:0] score0,
    output logic [5:0] score1,
    output logic [3:0] count0,
    output logic [3:0] count1,
    output logic       game_over,
    output logic [1:0] winner
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0] KEY_P0  = 4'b0011;
    localparam logic [3:0] KEY_P1  = 4'b0001;
    localparam logic [3:0] KEY_NEW = 4'b1111;

    localparam logic [5:0] TGT  = 6'(TARGET);
    localparam logic [3:0] MAXC = 4'(MAX_CARDS);

    logic [2:0] state;
    logic [3:0] prev_key;
    logic [4:0] rnd_q;

    logic       key_edge;
    logic       draw_ok;
    logic       do_clear;
    logic [1:0] dec_color;
    logic [2:0] dec_number;
    logic [5:0] cur_score;

    // A key only counts on the cycle its code first appears.
    assign key_edge = (keypad_in != prev_key);
    assign draw_ok  = key_edge && (keypad_in == (whose ? KEY_P1 : KEY_P0));
    assign do_clear = key_edge && (keypad_in == KEY_NEW) &&
                      ((state == S_IDLE) || (state == S_DONE));

    assign rnd_en    = (state == S_REQ);
    assign cur_score = whose ? score1 : score0;

    always_comb begin
        dec_color = 2'd1;
        case (rnd_q[4:3])
            2'b00:   dec_color = 2'd1;
            2'b01:   dec_color = 2'd2;
            2'b10:   dec_color = 2'd3;
            default: dec_color = 2'd1;
        endcase
    end

    // Values 5..7 fold back onto 1..3 so every draw is a legal card.
    always_comb begin
        dec_number = 3'd1;
        case (rnd_q[2:0])
            3'd0:    dec_number = 3'd1;
            3'd1:    dec_number = 3'd2;
            3'd2:    dec_number = 3'd3;
            3'd3:    dec_number = 3'd4;
            3'd4:    dec_number = 3'd5;
            3'd5:    dec_number = 3'd1;
            3'd6:    dec_number = 3'd2;
            default: dec_number = 3'd3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= S_IDLE;
            prev_key    <= 4'd0;
            rnd_q       <= 5'd0;
            whose       <= 1'b0;
            card_valid  <= 1'b0;
            card_color  <= 2'd0;
            card_number <= 3'd0;
            card_owner  <= 1'b0;
            score0      <= 6'd0;
            score1      <= 6'd0;
            count0      <= 4'd0;
            count1      <= 4'd0;
            game_over   <= 1'b0;
            winner      <= 2'b00;
        end else begin
            prev_key   <= keypad_in;
            card_valid <= 1'b0;
            if (do_clear) begin
                state       <= S_IDLE;
                whose       <= 1'b0;
                card_color  <= 2'd0;
                card_number <= 3'd0;
                card_owner  <= 1'b0;
                score0      <= 6'd0;
                score1      <= 6'd0;
                count0      <= 4'd0;
                count1      <= 4'd0;
                game_over   <= 1'b0;
                winner      <= 2'b00;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (draw_ok) state <= S_REQ;
                    end
                    S_REQ: begin
                        rnd_q <= rnd;
                        state <= S_ADD;
                    end
                    S_ADD: begin
                        card_valid  <= 1'b1;
                        card_color  <= dec_color;
                        card_number <= dec_number;
                        card_owner  <= whose;
                        if (whose) begin
                            score1 <= score1 + {3'b000, dec_number};
                            count1 <= count1 + 4'd1;
                        end else begin
                            score0 <= score0 + {3'b000, dec_number};
                            count0 <= count0 + 4'd1;
                        end
                        state <= S_CHECK;
                    end
                    S_CHECK: begin
                        // Bust outranks exact target, which outranks the card-limit comparison.
                        if (cur_score > TGT) begin
                            winner    <= whose ? 2'b01 : 2'b10;
                            game_over <= 1'b1;
                            state     <= S_DONE;
                        end else if (cur_score == TGT) begin
                            winner    <= whose ? 2'b10 : 2'b01;
                            game_over <= 1'b1;
                            state     <= S_DONE;
                        end else if ((count0 == MAXC) && (count1 == MAXC)) begin
                            if (score0 > score1)      winner <= 2'b01;
                            else if (score1 > score0) winner <= 2'b10;
                            else                      winner <= 2'b11;
                            game_over <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            whose <= ~whose;
                            state <= S_IDLE;
                        end
                    end
                    S_DONE: begin
                        state <= S_DONE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/deal_sequencer.md
# deal_sequencer

Turn-based dealing controller for the two-player card game. It accepts draw keys from the keypad and pulses the random generator enable to draw a card. It decodes the 5-bit random value into color/number, credits the card to the current player's hand and score, then either passes the turn or ends the game with a winner. It sits between keypad decode and the random generator, and replaces ad-hoc turn toggling and card demuxing with one sequenced flow.

## Interface
- TARGET, 21: score that wins outright; any score above it busts.
- MAX_CARDS, 8: cards per player before the game ends on points (1..15).
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- keypad_in  input  4  key code: 4'b0011 = player 0 draw, 4'b0001 = player 1 draw, 4'b1111 = new game
- rnd  input  5  random value; valid combinationally while rnd_en is high
- rnd_en  output  1  one-cycle draw request to the random generator
- whose  output  1  current turn (0 = player 0, 1 = player 1)
- card_valid  output  1  one-cycle pulse when card_color, card_number and card_owner are updated
- card_color  output  2  color of the last card (1..3)
- card_number  output  3  number of the last card (1..5)
- card_owner  output  1  player who received the last card
- score0, score1  output  6 each  running score per player
- count0, count1  output  4 each  cards held per player
- game_over  output  1  high while in DONE
- winner  output  2  00 none, 01 player 0, 10 player 1, 11 tie

## Operation
- **States:** IDLE, REQ, ADD, CHECK, DONE.
- **Key acceptance:**
  - A key is accepted only on a new press: keypad_in equals the code and the registered previous keypad_in differs.
  - Holding a key produces exactly one acceptance.
- **IDLE:**
  - Draw code matching whose → REQ. A draw code for the other player is ignored.
  - 4'b1111 → new-game clear; state stays IDLE.
- **REQ:** rnd_en = 1; rnd latched into an internal register; → ADD.
- **ADD:**
  - Color map from rnd[4:3]: 00→1, 01→2, 10→3, 11→1.
  - Number map from rnd[2:0]: 0..4 → 1..5, 5→1, 6→2, 7→3.
  - Register card_color, card_number, card_owner=whose; pulse card_valid.
  - Add number to the current player's score (6-bit; cannot overflow, max 5·15+... capped by bust); increment the current player's count; → CHECK.
- **CHECK (on the current player):**
  - score > TARGET → winner = other player, → DONE.
  - Else score == TARGET → winner = current player, → DONE.
  - Else count0 == MAX_CARDS and count1 == MAX_CARDS → compare scores: higher score wins, equal gives 11; → DONE.
  - Else toggle whose, → IDLE.
- **DONE:**
  - game_over = 1; all draw keys ignored.
  - 4'b1111 new press → new-game clear, → IDLE.
- **New-game clear:** scores, counts, card outputs, winner and game_over set to 0; whose = 0.
- No key is accepted in REQ, ADD or CHECK, including 4'b1111.

## Timing
- **Reset:** while rst=0 at a clock edge, state = IDLE and every output and the previous-key register are cleared to 0. Reset mid-draw aborts the draw: no card_valid and no score change.
- **Draw latency, key sampled at edge N:**
  - rnd_en high in cycle N+1 only.
  - card_valid, card fields, score and count updated at edge N+2.
  - whose toggles, or game_over/winner are set, at edge N+3.
  - Next key is accepted at edge N+3 at the earliest, i.e. one draw per 3 cycles.
- **Output registration:** rnd_en is decoded from state; all other outputs are registered.
- **Simultaneous events:** the bust check takes priority over the exact-TARGET check, which takes priority over the MAX_CARDS check.
- **Turn order:** player 0 always draws first after reset or new game. count1 reaches MAX_CARDS only on player 1's draw, so the points comparison happens there.

## Test plan
- **Reset:** drive rst=0 for 2 cycles → all outputs 0, whose=0, rnd_en never asserted.
- **Single draw:** whose=0, keypad 4'b0011 for 1 cycle, rnd=5'b01011. Expect:
  - rnd_en high exactly 1 cycle.
  - card_color=2, card_number=4, card_owner=0, score0=4, count0=1.
  - whose=1 three cycles after the key.
- **Key filtering:**
  - whose=0, keypad 4'b0001 → no rnd_en.
  - 4'b0011 held 10 cycles → exactly one draw.
  - 4'b1111 pressed during ADD → ignored.
- **Bust:** sequence draws to score0=20, then player 0 draws rnd=5'b00100 (number 5) → score0=25, game_over=1, winner=10. Further draw keys are ignored until 4'b1111, after which scores=0 and whose=0.
- **Exact target and tie:**
  - score1=16 plus a number-5 card → winner=10.
  - With MAX_CARDS=2, draws 3,2 for player 0 and 1,4 for player 1 → winner=11 after player 1's second card.
- **Reset mid-operation:** rst=0 in the cycle rnd_en is high → IDLE, scores unchanged at 0, no card_valid pulse.
